// File: rtl/pll_phase_sequencer_pkg.sv
// Shared types and constants for the PLL phase sequencer.
//   state_t     : sequencer FSM states
//   CSEL_*      : PLL phasecounterselect encodings
//   mod_steps() : reduce a value modulo the phase-step count
package pll_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECKSRC,
    CLKSW,
    WAITLOCK,
    PLAN,
    STEP_ASSERT,
    STEP_WAIT
  } state_t;

  localparam logic [2:0] CSEL_ALL = 3'b000;
  localparam logic [2:0] CSEL_M   = 3'b001;
  localparam logic [2:0] CSEL_C0  = 3'b010;
  localparam logic [2:0] CSEL_C1  = 3'b011;
  localparam logic [2:0] CSEL_C2  = 3'b100;
  localparam logic [2:0] CSEL_C3  = 3'b101;
  localparam logic [2:0] CSEL_C4  = 3'b110;

  function automatic logic [8:0] mod_steps(input logic [8:0] v, input int unsigned n);
    return 9'(32'(v) % n);
  endfunction

endpackage

// File: rtl/pll_phase_sequencer_scanclk_gen.sv
// Free-running scanclk divider.
//   clk, reset : system clock, synchronous active-high reset
//   scanclk    : clk / (2*DIV)
//   scan_rise  : high on the clk cycle whose closing edge raises scanclk
//   scan_fall  : high on the clk cycle whose closing edge lowers scanclk
module pll_phase_sequencer_scanclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic scanclk,
  output logic scan_rise,
  output logic scan_fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick      = (div_cnt == CW'(DIV - 1));
  assign scan_rise = tick & ~scanclk;
  assign scan_fall = tick &  scanclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      scanclk <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      scanclk <= ~scanclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pll_phase_sequencer.sv
// PLL dynamic phase / input-clock reconfiguration sequencer.
// Accepts absolute phase targets, optionally switches the PLL input clock,
// then issues the minimum number of single phase steps in the shortest
// direction while tracking the applied phase.
//   clk, reset                      : system clock, synchronous active-high reset
//   updatepll/pll_clk_src/phase     : request strobe and its target
//   phasedone/activeclock/pll_locked: PLL status inputs
//   phasecounterselect..clkswitch   : PLL control pins
//   busy, current_phase, error      : sequencer status
module pll_phase_sequencer
  import pll_phase_sequencer_pkg::*;
#(
  parameter int         NSTEPS       = 64,
  parameter int         SCANCLK_DIV  = 4,
  parameter logic [2:0] CNT_SEL      = CSEL_ALL,
  parameter int         CLKSW_CYCLES = 4,
  parameter int         TIMEOUT      = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       updatepll,
  input  logic       pll_clk_src,
  input  logic [7:0] pll_clk_phase,
  input  logic       phasedone,
  input  logic       activeclock,
  input  logic       pll_locked,
  output logic [2:0] phasecounterselect,
  output logic       phaseupdown,
  output logic       phasestep,
  output logic       scanclk,
  output logic       clkswitch,
  output logic       busy,
  output logic [7:0] current_phase,
  output logic       error
);

  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int CKW = (CLKSW_CYCLES > 1) ? $clog2(CLKSW_CYCLES) : 1;

  state_t         state;
  logic           pending;
  logic           tgt_src;
  logic [8:0]     tgt_phase;
  logic [8:0]     cur;
  logic [8:0]     steps;
  logic [TW-1:0]  tmo;
  logic [CKW-1:0] sw_cnt;
  logic [1:0]     stage;      // 0: wait a scanclk edge, 1: wait fall to assert, 2: holding
  logic [1:0]     rises;
  logic           seen_low;
  logic           step_q;
  logic           clksw_q;
  logic           scan_rise;
  logic           scan_fall;

  logic [8:0] sum, diff, cur_up, cur_dn;

  pll_phase_sequencer_scanclk_gen #(.DIV(SCANCLK_DIV)) u_scanclk (
    .clk       (clk),
    .reset     (reset),
    .scanclk   (scanclk),
    .scan_rise (scan_rise),
    .scan_fall (scan_fall)
  );

  // Reset must kill the strobes in the same cycle it is raised, not one later.
  assign phasestep          = step_q  & ~reset;
  assign clkswitch          = clksw_q & ~reset;
  assign phasecounterselect = CNT_SEL;
  assign current_phase      = cur[7:0];

  // Both operands are < NSTEPS, so one conditional subtract gives the modulo.
  always_comb begin
    sum    = tgt_phase + 9'(NSTEPS) - cur;
    diff   = (sum >= 9'(NSTEPS)) ? sum - 9'(NSTEPS) : sum;
    cur_up = (cur == 9'(NSTEPS - 1)) ? 9'd0 : cur + 9'd1;
    cur_dn = (cur == 9'd0) ? 9'(NSTEPS - 1) : cur - 9'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      tgt_src     <= 1'b0;
      tgt_phase   <= '0;
      cur         <= '0;
      steps       <= '0;
      tmo         <= '0;
      sw_cnt      <= '0;
      stage       <= '0;
      rises       <= '0;
      seen_low    <= 1'b0;
      step_q      <= 1'b0;
      clksw_q     <= 1'b0;
      phaseupdown <= 1'b1;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // Capture in any state; a later strobe simply overwrites the target.
      if (updatepll) begin
        tgt_src   <= pll_clk_src;
        tgt_phase <= mod_steps({1'b0, pll_clk_phase}, NSTEPS);
        pending   <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Accepting the strobe directly lets busy rise one clk after it.
          if (pending || updatepll) begin
            pending <= 1'b0;
            error   <= 1'b0;
            busy    <= 1'b1;
            state   <= CHECKSRC;
          end
        end

        CHECKSRC: begin
          if (tgt_src != activeclock) begin
            clksw_q <= 1'b1;
            sw_cnt  <= CKW'(CLKSW_CYCLES - 1);
            state   <= CLKSW;
          end else begin
            state <= PLAN;
          end
        end

        CLKSW: begin
          if (sw_cnt == '0) begin
            clksw_q <= 1'b0;
            tmo     <= '0;
            state   <= WAITLOCK;
          end else begin
            sw_cnt <= sw_cnt - CKW'(1);
          end
        end

        WAITLOCK: begin
          if (pll_locked) begin
            state <= PLAN;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        PLAN: begin
          if (diff == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (diff <= 9'(NSTEPS / 2)) begin
              phaseupdown <= 1'b1;
              steps       <= diff;
            end else begin
              phaseupdown <= 1'b0;
              steps       <= 9'(NSTEPS) - diff;
            end
            stage <= 2'd0;
            state <= STEP_ASSERT;
          end
        end

        STEP_ASSERT: begin
          case (stage)
            // A scan_rise must pass after phaseupdown settles before stepping.
            2'd0: if (scan_rise) stage <= 2'd1;
            2'd1: begin
              if (scan_fall) begin
                step_q <= 1'b1;
                rises  <= 2'd0;
                stage  <= 2'd2;
              end
            end
            default: begin
              if (scan_rise && rises != 2'd2) rises <= rises + 2'd1;
              if (scan_fall && rises == 2'd2) begin
                step_q   <= 1'b0;
                tmo      <= '0;
                seen_low <= 1'b0;
                state    <= STEP_WAIT;
              end
            end
          endcase
        end

        STEP_WAIT: begin
          if (!phasedone) seen_low <= 1'b1;
          if (seen_low && phasedone) begin
            cur   <= phaseupdown ? cur_up : cur_dn;
            steps <= steps - 9'd1;
            if (steps == 9'd1) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              stage <= 2'd0;
              state <= STEP_ASSERT;
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Self-checking bench for pll_phase_sequencer with a behavioural PLL model
// and a shortest-path phase reference model.
module tb_pll_phase_sequencer;

  localparam int N = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       updatepll = 1'b0;
  logic       pll_clk_src = 1'b0;
  logic [7:0] pll_clk_phase = 8'd0;
  logic       phasedone;
  logic       activeclock;
  logic       pll_locked;
  logic [2:0] phasecounterselect;
  logic       phaseupdown;
  logic       phasestep;
  logic       scanclk;
  logic       clkswitch;
  logic       busy;
  logic [7:0] current_phase;
  logic       error;

  pll_phase_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .updatepll          (updatepll),
    .pll_clk_src        (pll_clk_src),
    .pll_clk_phase      (pll_clk_phase),
    .phasedone          (phasedone),
    .activeclock        (activeclock),
    .pll_locked         (pll_locked),
    .phasecounterselect (phasecounterselect),
    .phaseupdown        (phaseupdown),
    .phasestep          (phasestep),
    .scanclk            (scanclk),
    .clkswitch          (clkswitch),
    .busy               (busy),
    .current_phase      (current_phase),
    .error              (error)
  );

  always #5 clk = ~clk;

  // ---------------- PLL model ----------------
  int   n_pulse = 0, n_up = 0, n_dn = 0, n_sw = 0, sw_run = 0, sw_width = 0;
  int   n_glitch = 0, n_zero = 0;
  int   pll_phase = 0, pd_dly = 0, pd_low = 0, lock_cnt = 0;
  int   lock_delay = 5;
  bit   stuck = 1'b0;
  logic ps_q = 1'b0, cs_q = 1'b0, ud_q = 1'b1;

  always @(negedge clk) begin
    if (reset) begin
      pll_phase   <= 0;
      phasedone   <= 1'b1;
      pll_locked  <= 1'b1;
      activeclock <= 1'b0;
      pd_dly      <= 0;
      pd_low      <= 0;
      lock_cnt    <= 0;
      sw_run      <= 0;
      ps_q        <= 1'b0;
      cs_q        <= 1'b0;
    end else begin
      ps_q <= phasestep;
      cs_q <= clkswitch;
      ud_q <= phaseupdown;
      if (phasestep && !ps_q) begin
        n_pulse <= n_pulse + 1;
        if (phaseupdown) begin
          n_up      <= n_up + 1;
          pll_phase <= (pll_phase + 1) % N;
        end else begin
          n_dn      <= n_dn + 1;
          pll_phase <= (pll_phase + N - 1) % N;
        end
      end
      if (phasestep && ps_q && phaseupdown !== ud_q) n_glitch <= n_glitch + 1;
      if (!phasestep && ps_q && !stuck) pd_dly <= $urandom_range(1, 3);
      if (pd_dly > 0) begin
        if (pd_dly == 1) begin
          phasedone <= 1'b0;
          pd_low    <= $urandom_range(1, 5);
        end
        pd_dly <= pd_dly - 1;
      end else if (pd_low > 0) begin
        if (pd_low == 1) phasedone <= 1'b1;
        pd_low <= pd_low - 1;
      end
      if (clkswitch) sw_run <= sw_run + 1;
      if (clkswitch && !cs_q) begin
        n_sw        <= n_sw + 1;
        pll_locked  <= 1'b0;
        activeclock <= ~activeclock;
      end
      if (!clkswitch && cs_q) begin
        sw_width <= sw_run;
        sw_run   <= 0;
        lock_cnt <= lock_delay;
      end
      if (lock_cnt > 0) begin
        if (lock_cnt == 1) pll_locked <= 1'b1;
        lock_cnt <= lock_cnt - 1;
      end
      if (busy && current_phase == 8'd0) n_zero <= n_zero + 1;
    end
  end

  // ---------------- checking ----------------
  int passed = 0, total = 0;
  int exp_cur = 0;
  int skew = 0;   // steps the PLL took that the sequencer did not record

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic strobe(input bit src, input int ph);
    @(negedge clk);
    pll_clk_src   = src;
    pll_clk_phase = 8'(ph);
    updatepll     = 1'b1;
    @(negedge clk);
    updatepll     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 8000) begin
      @(negedge clk);
      k++;
    end
    check({tag, ":idle"}, busy, 0);
  endtask

  // Reference: shortest distance on a ring of N, ties go up.
  task automatic do_op(input bit src, input int ph, input string tag);
    int p0, u0, d0, s0, d, eu, ed;
    bit sw;
    p0 = n_pulse; u0 = n_up; d0 = n_dn; s0 = n_sw;
    sw = (src != activeclock);
    d  = ((ph % N) - exp_cur + N) % N;
    eu = 0; ed = 0;
    if (d != 0) begin
      if (2 * d <= N) eu = d;
      else            ed = N - d;
    end
    strobe(src, ph);
    check({tag, ":busy_rise"}, busy, 1);
    wait_idle(tag);
    exp_cur = ph % N;
    check({tag, ":ups"},   n_up - u0, eu);
    check({tag, ":downs"}, n_dn - d0, ed);
    check({tag, ":pulses"}, n_pulse - p0, eu + ed);
    check({tag, ":cur"},   current_phase, exp_cur);
    check({tag, ":pll"},   pll_phase, (exp_cur + skew) % N);
    check({tag, ":nsw"},   n_sw - s0, sw ? 1 : 0);
    if (sw) check({tag, ":swwidth"}, sw_width, 4);
    check({tag, ":err"},   error, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int p0, u0, d0, s0, k, ph;
    bit src;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst:phasestep", phasestep, 0);
    check("rst:clkswitch", clkswitch, 0);
    check("rst:updown",    phaseupdown, 1);
    check("rst:csel",      phasecounterselect, 0);
    check("rst:scanclk",   scanclk, 0);
    check("rst:busy",      busy, 0);
    check("rst:error",     error, 0);
    check("rst:cur",       current_phase, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Up 5 steps, no clock switch
    do_op(1'b0, 5, "up5");

    // Down through zero: 5 -> 60 is 9 steps down
    k = n_zero;
    do_op(1'b0, 60, "wrap");
    check("wrap:passed_zero", (n_zero > k) ? 1 : 0, 1);

    // Input clock switch with slow lock, phase unchanged
    lock_delay = 50;
    p0 = n_pulse; s0 = n_sw;
    strobe(1'b1, 60);
    k = 0;
    while (n_sw == s0 && k < 100) begin @(negedge clk); k++; end
    repeat (45) @(negedge clk);
    check("sw:width",       sw_width, 4);
    check("sw:busy_waiting", busy, 1);
    check("sw:lock_low",    pll_locked, 0);
    wait_idle("sw");
    check("sw:pulses", n_pulse - p0, 0);
    check("sw:cur",    current_phase, 60);
    check("sw:err",    error, 0);
    lock_delay = 5;

    // Step timeout: phasedone never moves
    stuck = 1'b1;
    p0 = n_pulse;
    strobe(1'b1, 62);
    wait_idle("tmo");
    check("tmo:error",  error, 1);
    check("tmo:cur",    current_phase, 60);
    check("tmo:pulses", n_pulse - p0, 1);
    skew  = 1;
    stuck = 1'b0;
    strobe(1'b1, 60);
    check("tmo:err_clear", error, 0);
    wait_idle("tmo2");
    check("tmo2:cur", current_phase, 60);

    // Retarget mid-run: 10 completes, 3 is overwritten by 7
    p0 = n_pulse; u0 = n_up;
    strobe(1'b1, 10);
    k = 0;
    while (n_pulse == p0 && k < 2000) begin @(negedge clk); k++; end
    strobe(1'b1, 3);
    repeat (3) @(negedge clk);
    strobe(1'b1, 7);
    k = 0;
    while (busy && k < 8000) begin @(negedge clk); k++; end
    check("mid:gap_low",   busy, 0);
    check("mid:first_cur", current_phase, 10);
    check("mid:first_ups", n_up - u0, 14);
    d0 = n_dn;
    @(negedge clk);
    check("mid:rebusy", busy, 1);
    wait_idle("mid2");
    check("mid2:downs", n_dn - d0, 3);
    check("mid2:cur",   current_phase, 7);
    check("mid2:pll",   pll_phase, (7 + skew) % N);
    exp_cur = 7;

    // Randomised targets; first one lands exactly on the half-ring tie
    for (int i = 0; i < 8; i++) begin
      src = (i == 0) ? activeclock : 1'($urandom_range(0, 1));
      ph  = (i == 0) ? ((exp_cur + N / 2) % N) + N : int'($urandom_range(0, 255));
      lock_delay = $urandom_range(2, 20);
      do_op(src, ph, $sformatf("rnd%0d", i));
    end
    check("glitch_free_updown", n_glitch, 0);

    // Reset in the middle of a phasestep pulse
    strobe(activeclock, (exp_cur + 13) % N);
    k = 0;
    while (!phasestep && k < 2000) begin @(negedge clk); k++; end
    reset = 1'b1;
    #1;
    check("rstmid:phasestep", phasestep, 0);
    check("rstmid:clkswitch", clkswitch, 0);
    @(negedge clk);
    @(negedge clk);
    check("rstmid:cur",   current_phase, 0);
    check("rstmid:busy",  busy, 0);
    check("rstmid:error", error, 0);
    check("rstmid:updown", phaseupdown, 1);
    reset   = 1'b0;
    exp_cur = 0;
    skew    = 0;
    repeat (2) @(negedge clk);
    do_op(1'b0, 3, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pll_phase_sequencer.md
Name: pll_phase_sequencer

Overview:
Sequences the dynamic reconfiguration of the board PLL from the command processor's updatepll / pll_clk_src / pll_clk_phase outputs. On each update request it performs a clock-input switch if required, then issues the minimum number of single phase steps, in the shortest direction, to reach the requested phase. It drives the PLL's phasecounterselect/phaseupdown/phasestep/scanclk/clkswitch pins. It tracks the currently applied phase, so the processor only ever supplies absolute targets.

Parameters:
NSTEPS, 64, phase steps per full output period; valid range 2..256; targets are taken modulo NSTEPS
SCANCLK_DIV, 4, clk cycles per scanclk half-period (scanclk period = 2*SCANCLK_DIV clk)
CNT_SEL, 3'b000, phasecounterselect value (000 = all counters)
CLKSW_CYCLES, 4, clk cycles clkswitch is held high
TIMEOUT, 1023, clk cycles allowed for each phasedone or lock wait before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
updatepll  in  1  one-cycle request strobe
pll_clk_src  in  1  requested input clock (0 = inclk0)
pll_clk_phase  in  8  requested absolute phase, in steps
phasedone  in  1  from PLL; low while a step is in progress
activeclock  in  1  from PLL; input clock currently selected
pll_locked  in  1  from PLL lock output
phasecounterselect  out  3  to PLL
phaseupdown  out  1  to PLL; 1 = up
phasestep  out  1  to PLL
scanclk  out  1  to PLL
clkswitch  out  1  to PLL
busy  out  1  high from request acceptance until return to IDLE
current_phase  out  8  phase currently applied, 0..NSTEPS-1
error  out  1  sticky timeout flag; cleared by the next accepted request

Behaviour:
- Reset values: phasestep=0, clkswitch=0, phaseupdown=1, phasecounterselect=CNT_SEL, scanclk=0, busy=0, error=0, current_phase=0, pending=0, divider=0, state IDLE. Reset mid-operation aborts immediately; phasestep/clkswitch drop the same cycle. The PLL areset is tied to the same reset, so phase 0 is correct after reset.
- scanclk runs continuously from a divider. Internal strobes scan_rise/scan_fall mark the clk cycle on which scanclk toggles.
- Request capture: updatepll in any state latches tgt_src=pll_clk_src, tgt_phase=pll_clk_phase mod NSTEPS, and sets pending. A new strobe while busy overwrites the latched target (last wins). The new target runs after the current operation completes.
- IDLE: if pending, clear pending and error, set busy, go to CHECKSRC. busy rises 1 clk after the strobe.
- CHECKSRC: if tgt_src != activeclock go to CLKSW, else go to PLAN.
- CLKSW: clkswitch=1 for exactly CLKSW_CYCLES clk, then go to WAITLOCK.
- WAITLOCK: wait for pll_locked=1, then go to PLAN. On timeout: error=1, go to IDLE.
- PLAN: diff=(tgt_phase-current_phase) mod NSTEPS.
  - diff=0: go to IDLE.
  - diff<=NSTEPS/2: phaseupdown=1, steps=diff.
  - otherwise: phaseupdown=0, steps=NSTEPS-diff.
  - A tie at exactly NSTEPS/2 goes up.
  - phaseupdown is set at least one scanclk edge before phasestep.
- STEP_ASSERT: on scan_fall set phasestep=1. Hold it through two scan_rise strobes, then clear it on the next scan_fall.
- STEP_WAIT: wait for phasedone low, then high (timeout covers both). Then current_phase +/-1 mod NSTEPS (wrap NSTEPS-1<->0) and steps-1. If steps=0 go to IDLE, else go to STEP_ASSERT.
- Step timeout: error=1, current_phase is not updated, go to IDLE. A pending request is still serviced afterwards.
- busy falls on the clk cycle that IDLE is re-entered. If pending is set, busy re-asserts the next cycle.
- All arithmetic on current_phase is 9-bit internally to avoid overflow at NSTEPS=256.

Decomposition:
- Shared package: state enum (IDLE, CHECKSRC, CLKSW, WAITLOCK, PLAN, STEP_ASSERT, STEP_WAIT), counter-select constants (CSEL_ALL=000, CSEL_M=001, CSEL_C0=010 ... CSEL_C4=110).
- One sub-module: scanclk_gen (divider producing scanclk, scan_rise, scan_fall; synchronous reset).

Test Plan:
- Reset, then strobe phase=5, src=0, activeclock=0 -> no clkswitch; exactly 5 phasestep pulses with phaseupdown=1; current_phase=5; busy low afterwards.
- From phase 5 (NSTEPS=64), strobe phase=60 -> phaseupdown=0, 9 steps; current_phase passes 0 and ends at 60.
- Strobe src=1 while activeclock=0 -> clkswitch high 4 clk; hold pll_locked=0 for 50 clk then 1 -> PLAN entered; 0 steps if phase unchanged.
- Hold phasedone=1 (never pulses) -> after 1023 clk error=1, current_phase unchanged, busy=0. Next strobe clears error.
- Strobe phase=10 then, mid-sequence, strobes phase=3 then phase=7 -> first run reaches 10; second run goes down 3 steps to 7; phase=3 is never applied.
- Assert reset during a phasestep pulse -> phasestep=0 that cycle; current_phase=0, busy=0, error=0.
